// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issue/writeback controller for an external 8-bit ALU.
// One instruction per handshake, sequenced IDLE -> EXEC -> WB -> IDLE.
// Operands come from a 4x8 register file. Results and {Z,N,C,V} flags are
// committed in WB, and conditional branches are evaluated against the latched flags.
// Optional feature macro: ALU_SEQ_CTRL_ILLEGAL_TRAP_EN (opcodes 1100-1111
// raise err and park the block in HALT until reset).
module alu_seq_ctrl #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [3:0]            alu_sel,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_z,
  input  logic                  alu_n,
  input  logic                  alu_c,
  input  logic                  alu_v,
  output logic [3:0]            flags,
  output logic                  done,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target,
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  err
);

  localparam int NREGS = 1 << REG_ADDR_W;

  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_BR  = 4'b1011;

`ifdef ALU_SEQ_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
`endif

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        hflags_q, hflags_d;
  logic [3:0]        flags_q, flags_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd;
  logic                  cond_ok;

  assign op = instr_q[15:12];
  assign rd = instr_q[11:10];

  // Branch condition, evaluated against flags as they stood before this branch.
  always_comb begin
    cond_ok = 1'b1;
    case (instr_q[11:8])
      4'd0:    cond_ok = flags_q[3];
      4'd1:    cond_ok = ~flags_q[3];
      4'd2:    cond_ok = flags_q[1];
      4'd3:    cond_ok = flags_q[2];
      4'd4:    cond_ok = flags_q[0];
      default: cond_ok = 1'b1;
    endcase
  end

  // Next-state, datapath capture and writeback commit.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    res_d     = res_q;
    hflags_d  = hflags_q;
    flags_d   = flags_q;
    for (int unsigned i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d   = instr;
          alu_a_d   = regs_q[instr[11:10]];
          alu_b_d   = regs_q[instr[9:8]];
          alu_sel_d = instr[15:12];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d    = alu_result;
        hflags_d = {alu_z, alu_n, alu_c, alu_v};
        state_d  = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
        if (op <= OP_CMP) begin
          flags_d = hflags_q;
          if (op != OP_CMP) regs_d[rd] = res_q;
        end else if (op == OP_LDI) begin
          regs_d[rd] = instr_q[7:0];
        end
`ifdef ALU_SEQ_CTRL_ILLEGAL_TRAP_EN
        else if (op > OP_BR) begin
          state_d = S_HALT;
        end
`endif
      end
`ifdef ALU_SEQ_CTRL_ILLEGAL_TRAP_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      hflags_q  <= '0;
      flags_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      hflags_q  <= hflags_d;
      flags_q   <= flags_d;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Status and branch outputs decoded from the current state.
  always_comb begin
    instr_ready   = (state_q == S_IDLE);
    done          = (state_q == S_WB);
    branch_taken  = done && (op == OP_BR) && cond_ok;
    branch_target = branch_taken ? instr_q[7:0] : '0;
`ifdef ALU_SEQ_CTRL_ILLEGAL_TRAP_EN
    err = (state_q == S_HALT) || (done && (op > OP_BR));
`else
    err = 1'b0;
`endif
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign flags    = flags_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl. It contains a behavioural ALU stub and an
// instruction-level model that feeds a scoreboard of expected retirements.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_a, alu_b, alu_result, branch_target, dbg_data;
  logic [3:0]  alu_sel, flags;
  logic        alu_z, alu_n, alu_c, alu_v, done, branch_taken, err;
  logic [1:0]  dbg_sel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] regs;
    logic [3:0]  flags;
    logic        bt;
    logic [7:0]  tgt;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  m_regs [4];
  logic [3:0]  m_flags;

  int          obs_lat;
  logic        obs_to, obs_bt, obs_err, obs_done2, obs_ready2;
  logic [7:0]  obs_tgt;
  logic [31:0] obs_regs;
  logic [3:0]  obs_flags;

  alu_seq_ctrl #(.DATA_W(8), .REG_ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
    .alu_v(alu_v), .flags(flags), .done(done), .branch_taken(branch_taken),
    .branch_target(branch_target), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .err(err)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {result, Z, N, C, V}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic c, v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1, 4'd9: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd8: begin t = {1'b0, a} + 9'd1; r = t[7:0]; c = t[8]; v = (a == 8'h7F); end
      default: r = '0;
    endcase
    return {r, (r == 8'h00), r[7], c, v};
  endfunction

  // ALU stub driven from whatever the controller presents.
  always_comb {alu_result, alu_z, alu_n, alu_c, alu_v} = alu_fn(alu_sel, alu_a, alu_b);

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags = 4'h0;
  endtask

  task automatic model_apply(input logic [15:0] ins);
    exp_t e;
    logic [3:0] op;
    logic [11:0] r;
    logic c;
    op = ins[15:12];
    e.bt = 1'b0; e.tgt = 8'h00; e.err = 1'b0;
    if (op <= 4'd9) begin
      r = alu_fn(op, m_regs[ins[11:10]], m_regs[ins[9:8]]);
      m_flags = r[3:0];
      if (op != 4'd9) m_regs[ins[11:10]] = r[11:4];
    end else if (op == 4'd10) begin
      m_regs[ins[11:10]] = ins[7:0];
    end else if (op == 4'd11) begin
      case (ins[11:8])
        4'd0: c = m_flags[3];
        4'd1: c = !m_flags[3];
        4'd2: c = m_flags[1];
        4'd3: c = m_flags[2];
        4'd4: c = m_flags[0];
        default: c = 1'b1;
      endcase
      e.bt = c;
      e.tgt = c ? ins[7:0] : 8'h00;
    end else begin
`ifdef ALU_SEQ_CTRL_ILLEGAL_TRAP_EN
      e.err = 1'b1;
`endif
    end
    e.regs = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    e.flags = m_flags;
    sb.push_back(e);
  endtask

  task automatic read_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      obs_regs[i*8 +: 8] = dbg_data;
    end
  endtask

  // Issue one instruction and record what the DUT did; comparisons live in the tests.
  task automatic run_instr(input logic [15:0] ins);
    int n;
    obs_to = 1'b0;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) obs_to = 1'b1;
    instr = ins; instr_valid = 1'b1;
    @(posedge clk);
    model_apply(ins);
    @(negedge clk);
    instr_valid = 1'b0;
    n = 1;
    while (!done && n < 10) begin @(negedge clk); n++; end
    if (!done) obs_to = 1'b1;
    obs_lat = n;
    obs_bt = branch_taken; obs_tgt = branch_target; obs_err = err;
    @(negedge clk);
    obs_done2 = done; obs_ready2 = instr_ready;
    read_regs();
    obs_flags = flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = '0; instr_valid = 1'b0; dbg_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_regs();
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || branch_taken !== 1'b0 || branch_target !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status ready=%b done=%b bt=%b tgt=%h err=%b required 1 0 0 00 0", instr_ready, done, branch_taken, branch_target, err);
    end
    checks++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 4'h0 || flags !== 4'h0 || obs_regs !== 32'h0) begin
      errors++;
      $display("FAIL reset_state a=%h b=%h sel=%h flags=%h regs=%h required all zero", alu_a, alu_b, alu_sel, flags, obs_regs);
    end
  endtask

  task automatic test_arith();
    logic [15:0] prog [3] = '{16'hA47F, 16'hA801, 16'h0600};
    exp_t e;
    foreach (prog[i]) begin
      run_instr(prog[i]);
      e = sb.pop_front();
      checks++;
      if (obs_to || obs_lat !== 2 || obs_bt !== e.bt || obs_tgt !== e.tgt || obs_err !== e.err || obs_done2 !== 1'b0 || obs_ready2 !== 1'b1) begin
        errors++;
        $display("FAIL arith_retire ins=%h to=%b lat=%0d bt=%b tgt=%h err=%b done2=%b ready2=%b required lat=2 bt=%b tgt=%h err=%b done2=0 ready2=1",
                 prog[i], obs_to, obs_lat, obs_bt, obs_tgt, obs_err, obs_done2, obs_ready2, e.bt, e.tgt, e.err);
      end
      checks++;
      if (obs_regs !== e.regs || obs_flags !== e.flags) begin
        errors++;
        $display("FAIL arith_state ins=%h regs=%h flags=%b required regs=%h flags=%b", prog[i], obs_regs, obs_flags, e.regs, e.flags);
      end
    end
    checks++;
    if (obs_regs[15:8] !== 8'h80 || obs_flags !== 4'b0101) begin
      errors++;
      $display("FAIL add_overflow r1=%h flags=%b required r1=80 flags=0101", obs_regs[15:8], obs_flags);
    end
  endtask

  task automatic test_cmp_branch();
    logic [15:0] prog [4] = '{16'hA005, 16'h9000, 16'hB03C, 16'hB13C};
    exp_t e;
    foreach (prog[i]) begin
      run_instr(prog[i]);
      e = sb.pop_front();
      checks++;
      if (obs_to || obs_lat !== 2 || obs_bt !== e.bt || obs_tgt !== e.tgt || obs_err !== e.err || obs_done2 !== 1'b0) begin
        errors++;
        $display("FAIL br_retire ins=%h to=%b lat=%0d bt=%b tgt=%h err=%b done2=%b required lat=2 bt=%b tgt=%h err=%b done2=0",
                 prog[i], obs_to, obs_lat, obs_bt, obs_tgt, obs_err, obs_done2, e.bt, e.tgt, e.err);
      end
      checks++;
      if (obs_regs !== e.regs || obs_flags !== e.flags) begin
        errors++;
        $display("FAIL br_state ins=%h regs=%h flags=%b required regs=%h flags=%b", prog[i], obs_regs, obs_flags, e.regs, e.flags);
      end
      if (i == 2) begin
        checks++;
        if (obs_bt !== 1'b1 || obs_tgt !== 8'h3C || obs_regs[7:0] !== 8'h05 || obs_flags[3:2] !== 2'b10) begin
          errors++;
          $display("FAIL beq_taken bt=%b tgt=%h r0=%h zn=%b required bt=1 tgt=3c r0=05 zn=10", obs_bt, obs_tgt, obs_regs[7:0], obs_flags[3:2]);
        end
      end
    end
  endtask

  task automatic test_shift();
    logic [15:0] prog [4] = '{16'hAC81, 16'h6C00, 16'h7C00, 16'h8C00};
    logic [7:0]  r3 [4] = '{8'h81, 8'h02, 8'h01, 8'h02};
    exp_t e;
    foreach (prog[i]) begin
      run_instr(prog[i]);
      e = sb.pop_front();
      checks++;
      if (obs_to || obs_lat !== 2 || obs_regs !== e.regs || obs_flags !== e.flags || obs_regs[31:24] !== r3[i]) begin
        errors++;
        $display("FAIL shift ins=%h lat=%0d regs=%h flags=%b required lat=2 regs=%h flags=%b r3=%h",
                 prog[i], obs_lat, obs_regs, obs_flags, e.regs, e.flags, r3[i]);
      end
    end
  endtask

  task automatic test_all_ops();
    logic [15:0] prog [14] = '{16'hA03C, 16'hA4A5, 16'h1100, 16'hB25A, 16'h2100, 16'h3400,
                               16'hB3C3, 16'h4500, 16'h5000, 16'h0400, 16'hB411, 16'hB777,
                               16'hF0F0, 16'hE5AA};
    exp_t e;
    foreach (prog[i]) begin
      run_instr(prog[i]);
      e = sb.pop_front();
      checks++;
      if (obs_to || obs_lat !== 2 || obs_bt !== e.bt || obs_tgt !== e.tgt || obs_err !== e.err ||
          obs_regs !== e.regs || obs_flags !== e.flags) begin
        errors++;
        $display("FAIL op_mix ins=%h lat=%0d bt=%b tgt=%h err=%b regs=%h flags=%b required lat=2 bt=%b tgt=%h err=%b regs=%h flags=%b",
                 prog[i], obs_lat, obs_bt, obs_tgt, obs_err, obs_regs, obs_flags, e.bt, e.tgt, e.err, e.regs, e.flags);
      end
`ifdef ALU_SEQ_CTRL_ILLEGAL_TRAP_EN
      if (prog[i][15:12] > 4'd11) begin
        checks++;
        if (obs_ready2 !== 1'b0 || err !== 1'b1) begin
          errors++;
          $display("FAIL halt ready=%b err=%b required ready=0 err=1", obs_ready2, err);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (instr_ready !== (i % 3 == 0)) begin
        errors++;
        $display("FAIL hold_ready cycle=%0d ready=%b required %b", i, instr_ready, (i % 3 == 0));
      end
      instr = {4'hA, 2'(i % 4), 2'b00, 8'(8'h10 + i)};
      instr_valid = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    m_regs[0] = 8'h10; m_regs[3] = 8'h13; m_regs[2] = 8'h16;
    for (int i = 0; i < 4; i++) want[i] = m_regs[i];
    read_regs();
    checks++;
    if (obs_regs !== {want[3], want[2], want[1], want[0]} || flags !== m_flags) begin
      errors++;
      $display("FAIL hold_accept regs=%h flags=%b required regs=%h flags=%b", obs_regs, flags, {want[3], want[2], want[1], want[0]}, m_flags);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] prog [2] = '{16'hA410, 16'hA822};
    exp_t e;
    logic seen;
    foreach (prog[i]) begin
      run_instr(prog[i]);
      e = sb.pop_front();
      checks++;
      if (obs_to || obs_regs !== e.regs) begin
        errors++;
        $display("FAIL rst_setup ins=%h regs=%h required %h", prog[i], obs_regs, e.regs);
      end
    end
    instr = 16'h0600; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = done;
    read_regs();
    checks++;
    if (instr_ready !== 1'b1 || obs_regs !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL rst_exec ready=%b regs=%h flags=%b required ready=1 regs=0 flags=0", instr_ready, obs_regs, flags);
    end
    repeat (3) begin @(negedge clk); seen = seen | done; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done done_seen=%b required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_cmp_branch();
    test_shift();
    test_all_ops();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left entries=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
